draw_priority_arbiter: RTL and testbench

Per-pixel arbiter that sits directly upstream of the VGA objects multiplexer. It resolves the per-object draw requests into a registered 8-bit object code that drives the mux's object_to_draw select. It also accumulates frog collision events over each frame and publishes them at frame start for the game-control logic.

---
 rtl/draw_priority_arbiter_if.sv | 33 +++
 rtl/draw_priority_arbiter.sv | 117 +++++++++++
 tb/tb_draw_priority_arbiter.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/draw_priority_arbiter_if.sv
`timescale 1ns/1ps
`default_nettype none
// ------------------------------------------------------------------
// draw_priority_arbiter_if : per-pixel draw requests and arbiter results
// Rev 1.0
// ------------------------------------------------------------------
interface draw_priority_arbiter_if;
  logic       startOfFrame;
  logic       frog_draw;
  logic       log_draw;
  logic       waterfall_draw;
  logic       endbank_draw;
  logic       french_draw;
  logic [7:0] object_to_draw;
  logic       frog_on_log;
  logic       frog_drowned;
  logic       frog_at_endbank;
  logic       frog_hit;
  logic       collision_valid;

  modport master (
    output startOfFrame, frog_draw, log_draw, waterfall_draw, endbank_draw, french_draw,
    input  object_to_draw, frog_on_log, frog_drowned, frog_at_endbank, frog_hit,
           collision_valid
  );

  modport slave (
    input  startOfFrame, frog_draw, log_draw, waterfall_draw, endbank_draw, french_draw,
    output object_to_draw, frog_on_log, frog_drowned, frog_at_endbank, frog_hit,
           collision_valid
  );
endinterface
`default_nettype wire

// File: rtl/draw_priority_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ------------------------------------------------------------------
// draw_priority_arbiter : registered object select + per-frame frog collision flags
// Rev 1.0
// ------------------------------------------------------------------
module draw_priority_arbiter #(
  parameter int DROWN_THRESH = 64,
  parameter int CNT_W        = 12
) (
  input  logic                    CLK,
  input  logic                    RESETn,
  draw_priority_arbiter_if.slave  bus
);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_e;

  localparam logic [2:0]  C_BACKGROUND = 3'd0;
  localparam logic [2:0]  C_WATERFALL  = 3'd1;
  localparam logic [2:0]  C_LOG        = 3'd2;
  localparam logic [2:0]  C_FROG       = 3'd3;
  localparam logic [2:0]  C_ENDBANK    = 3'd4;
  localparam logic [2:0]  C_FRENCH     = 3'd5;
  localparam logic [31:0] C_THRESH     = 32'(DROWN_THRESH);

  state_e           state_q;
  logic [2:0]       obj_d;
  logic [2:0]       obj_q;
  logic             acc_log_q;
  logic             acc_bank_q;
  logic             acc_hit_q;
  logic [CNT_W-1:0] water_cnt_q;
  logic [CNT_W-1:0] water_cnt_d;
  logic             on_log_q;
  logic             drowned_q;
  logic             at_bank_q;
  logic             hit_q;
  logic             valid_q;

  logic ev_on_log;
  logic ev_in_water;
  logic ev_at_bank;
  logic ev_hit;
  logic drown_now;

  assign ev_on_log   = bus.frog_draw & bus.log_draw;
  assign ev_in_water = bus.frog_draw & bus.waterfall_draw & ~bus.log_draw;
  assign ev_at_bank  = bus.frog_draw & bus.endbank_draw;
  assign ev_hit      = bus.frog_draw & bus.french_draw;
  assign drown_now   = 32'(water_cnt_q) >= C_THRESH;

  always_comb begin
    obj_d = C_BACKGROUND;
    if (bus.french_draw)         obj_d = C_FRENCH;
    else if (bus.frog_draw)      obj_d = C_FROG;
    else if (bus.endbank_draw)   obj_d = C_ENDBANK;
    else if (bus.log_draw)       obj_d = C_LOG;
    else if (bus.waterfall_draw) obj_d = C_WATERFALL;
  end

  // Saturate at all-ones so a long swim never wraps back below the threshold.
  always_comb begin
    water_cnt_d = water_cnt_q;
    if (!(&water_cnt_q)) water_cnt_d = water_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge CLK) begin
    if (!RESETn) begin
      state_q     <= S_IDLE;
      obj_q       <= C_BACKGROUND;
      acc_log_q   <= 1'b0;
      acc_bank_q  <= 1'b0;
      acc_hit_q   <= 1'b0;
      water_cnt_q <= '0;
      on_log_q    <= 1'b0;
      drowned_q   <= 1'b0;
      at_bank_q   <= 1'b0;
      hit_q       <= 1'b0;
      valid_q     <= 1'b0;
    end else begin
      obj_q   <= obj_d;
      valid_q <= 1'b0;
      if (bus.startOfFrame) begin
        // The first frame boundary after reset only arms publishing.
        if (state_q == S_RUN) begin
          on_log_q  <= acc_log_q;
          drowned_q <= drown_now;
          at_bank_q <= acc_bank_q;
          hit_q     <= acc_hit_q;
          valid_q   <= 1'b1;
        end
        state_q     <= S_RUN;
        acc_log_q   <= ev_on_log;
        acc_bank_q  <= ev_at_bank;
        acc_hit_q   <= ev_hit;
        water_cnt_q <= CNT_W'(ev_in_water);
      end else begin
        acc_log_q  <= acc_log_q | ev_on_log;
        acc_bank_q <= acc_bank_q | ev_at_bank;
        acc_hit_q  <= acc_hit_q | ev_hit;
        if (ev_in_water) water_cnt_q <= water_cnt_d;
      end
    end
  end

  assign bus.object_to_draw  = {5'b00000, obj_q};
  assign bus.frog_on_log     = on_log_q;
  assign bus.frog_drowned    = drowned_q;
  assign bus.frog_at_endbank = at_bank_q;
  assign bus.frog_hit        = hit_q;
  assign bus.collision_valid = valid_q;

endmodule
`default_nettype wire

// File: tb/tb_draw_priority_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ------------------------------------------------------------------
// tb_draw_priority_arbiter : scoreboard bench for draw_priority_arbiter
// Rev 1.0
// ------------------------------------------------------------------
module tb_draw_priority_arbiter;

  typedef struct packed {
    logic [7:0] code;
    logic       cv;
    logic [3:0] flags;  // {on_log, drowned, at_endbank, hit}
  } exp_t;

  logic CLK = 1'b0;
  logic RESETn;
  int   errors = 0;
  int   checks = 0;
  logic [3:0] held = 4'b0000;
  exp_t exp_q[$];
  exp_t obs_q[$];

  always #5 CLK = ~CLK;

  draw_priority_arbiter_if bus ();
  draw_priority_arbiter_if bus2 ();

  draw_priority_arbiter dut (
    .CLK    (CLK),
    .RESETn (RESETn),
    .bus    (bus.slave)
  );

  draw_priority_arbiter #(.DROWN_THRESH(15), .CNT_W(4)) dut2 (
    .CLK    (CLK),
    .RESETn (RESETn),
    .bus    (bus2.slave)
  );

  function automatic logic [7:0] prio(input logic f, l, w, b, r);
    if (r) return 8'd5;
    if (f) return 8'd3;
    if (b) return 8'd4;
    if (l) return 8'd2;
    if (w) return 8'd1;
    return 8'd0;
  endfunction

  // Drives one pixel on the main DUT; pub/fl give the publish expected from this pixel's edge.
  task automatic drive(input logic rn, sof, f, l, w, b, r, input logic pub, input logic [3:0] fl);
    exp_t e;
    exp_t o;
    RESETn             = rn;
    bus.startOfFrame   = sof;
    bus.frog_draw      = f;
    bus.log_draw       = l;
    bus.waterfall_draw = w;
    bus.endbank_draw   = b;
    bus.french_draw    = r;
    if (!rn) held = 4'b0000;
    else if (pub) held = fl;
    e.code  = rn ? prio(f, l, w, b, r) : 8'd0;
    e.cv    = rn & pub;
    e.flags = held;
    exp_q.push_back(e);
    @(posedge CLK);
    #1;
    o.code  = bus.object_to_draw;
    o.cv    = bus.collision_valid;
    o.flags = {bus.frog_on_log, bus.frog_drowned, bus.frog_at_endbank, bus.frog_hit};
    obs_q.push_back(o);
  endtask

  task automatic test_reset();
    exp_t e;
    exp_t o;
    repeat (3) drive(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 4'b0000);
    drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 4'b0000);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL reset: got code=%0d cv=%b flags=%b, required code=%0d cv=%b flags=%b",
                 o.code, o.cv, o.flags, e.code, e.cv, e.flags);
      end
    end
  endtask

  task automatic test_priority();
    exp_t e;
    exp_t o;
    drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000);
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0000);
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0000);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0000);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000);
    drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 4'b0000);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL priority: got code=%0d cv=%b flags=%b, required code=%0d cv=%b flags=%b",
                 o.code, o.cv, o.flags, e.code, e.cv, e.flags);
      end
    end
  endtask

  task automatic test_drown();
    exp_t e;
    exp_t o;
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000);
    repeat (63) drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0000);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0000);
    repeat (64) drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0000);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0100);
    repeat (64) drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0000);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'b1000);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL drown: got code=%0d cv=%b flags=%b, required code=%0d cv=%b flags=%b",
                 o.code, o.cv, o.flags, e.code, e.cv, e.flags);
      end
    end
  endtask

  task automatic test_boundary();
    exp_t e;
    exp_t o;
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'b0000);
    repeat (3) drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0001);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL boundary: got code=%0d cv=%b flags=%b, required code=%0d cv=%b flags=%b",
                 o.code, o.cv, o.flags, e.code, e.cv, e.flags);
      end
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    exp_t o;
    drive(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0000);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'b1000);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0000);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL back_to_back: got code=%0d cv=%b flags=%b, required code=%0d cv=%b flags=%b",
                 o.code, o.cv, o.flags, e.code, e.cv, e.flags);
      end
    end
  endtask

  task automatic test_mid_reset();
    exp_t e;
    exp_t o;
    repeat (3) drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0000);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000);
    repeat (2) drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0000);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL mid_reset: got code=%0d cv=%b flags=%b, required code=%0d cv=%b flags=%b",
                 o.code, o.cv, o.flags, e.code, e.cv, e.flags);
      end
    end
  endtask

  // Narrow-counter instance: 40 swim pixels must pin the count at 15, not wrap to 8.
  task automatic test_saturation();
    exp_t e;
    exp_t o;
    bus2.startOfFrame = 1'b1;
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000);
    bus2.startOfFrame   = 1'b0;
    bus2.frog_draw      = 1'b1;
    bus2.waterfall_draw = 1'b1;
    repeat (40) drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000);
    bus2.frog_draw      = 1'b0;
    bus2.waterfall_draw = 1'b0;
    checks++;
    if (dut2.water_cnt_q !== 4'd15) begin
      errors++;
      $display("FAIL sat_count: got %0d, required 15", dut2.water_cnt_q);
    end
    bus2.startOfFrame = 1'b1;
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000);
    bus2.startOfFrame = 1'b0;
    checks++;
    if ({bus2.collision_valid, bus2.frog_drowned} !== 2'b11) begin
      errors++;
      $display("FAIL sat_drowned: got cv=%b drowned=%b, required cv=1 drowned=1",
               bus2.collision_valid, bus2.frog_drowned);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++;
        $display("FAIL saturation_main: got code=%0d cv=%b flags=%b, required code=%0d cv=%b flags=%b",
                 o.code, o.cv, o.flags, e.code, e.cv, e.flags);
      end
    end
  endtask

  initial begin
    RESETn              = 1'b0;
    bus.startOfFrame    = 1'b0;
    bus.frog_draw       = 1'b0;
    bus.log_draw        = 1'b0;
    bus.waterfall_draw  = 1'b0;
    bus.endbank_draw    = 1'b0;
    bus.french_draw     = 1'b0;
    bus2.startOfFrame   = 1'b0;
    bus2.frog_draw      = 1'b0;
    bus2.log_draw       = 1'b0;
    bus2.waterfall_draw = 1'b0;
    bus2.endbank_draw   = 1'b0;
    bus2.french_draw    = 1'b0;
    test_reset();
    test_priority();
    test_drown();
    test_boundary();
    test_back_to_back();
    test_mid_reset();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
